// File: rtl/pipeline_hazard_controller.sv
// Stall/flush/run sequencer for the 5-stage pipeline: resolves load-use and
// branch-in-ID hazards, runs the debug run/step/halt FSM and keeps counters.
module pipeline_hazard_controller #(
  parameter int NB_REG = 5,
  parameter int NB_CNT = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [NB_REG-1:0] i_rs_from_ID,
  input  logic [NB_REG-1:0] i_rt_from_ID,
  input  logic              i_uses_rs_ID,
  input  logic              i_uses_rt_ID,
  input  logic              i_branch_ID,
  input  logic              i_take_ID,
  input  logic              i_halt_ID,
  input  logic [NB_REG-1:0] i_rd_from_EX,
  input  logic              i_RegWrite_from_EX,
  input  logic              i_MemRead_from_EX,
  input  logic [NB_REG-1:0] i_rd_from_M,
  input  logic              i_MemRead_from_M,
  input  logic              i_start,
  input  logic              i_dbg_mode,
  input  logic              i_step,
  output logic              o_pc_en,
  output logic              o_if_id_en,
  output logic              o_if_id_flush,
  output logic              o_id_ex_bubble,
  output logic              o_back_en,
  output logic              o_halted,
  output logic [2:0]        o_state,
  output logic [NB_CNT-1:0] o_cycle_count,
  output logic [15:0]       o_stall_count
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RUN       = 3'd1,
    S_STEP_WAIT = 3'd2,
    S_STEP      = 3'd3,
    S_DRAIN     = 3'd4,
    S_HALTED    = 3'd5
  } state_t;

  localparam logic [NB_CNT-1:0] CNT_ONE   = NB_CNT'(1);
  localparam logic [1:0]        DRAIN_END = 2'd2;

  state_t            state_q, state_d;
  logic [1:0]        drain_cnt_q, drain_cnt_d;
  logic [NB_CNT-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [15:0]       stall_cnt_q, stall_cnt_d;

  logic ex_match, m_match, hazard;

  // A producer register matches only if nonzero and actually read by the ID instruction.
  assign ex_match = (i_rd_from_EX != '0) &&
                    ((i_uses_rs_ID && (i_rd_from_EX == i_rs_from_ID)) ||
                     (i_uses_rt_ID && (i_rd_from_EX == i_rt_from_ID)));
  assign m_match  = (i_rd_from_M != '0) &&
                    ((i_uses_rs_ID && (i_rd_from_M == i_rs_from_ID)) ||
                     (i_uses_rt_ID && (i_rd_from_M == i_rt_from_ID)));
  assign hazard   = (i_MemRead_from_EX && ex_match) ||
                    (i_branch_ID && i_RegWrite_from_EX && ex_match) ||
                    (i_branch_ID && i_MemRead_from_M && m_match);

  always_comb begin
    state_d        = state_q;
    drain_cnt_d    = drain_cnt_q;
    stall_cnt_d    = stall_cnt_q;
    o_pc_en        = 1'b0;
    o_if_id_en     = 1'b0;
    o_if_id_flush  = 1'b0;
    o_id_ex_bubble = 1'b0;
    o_back_en      = 1'b0;
    o_halted       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (i_start) state_d = i_dbg_mode ? S_STEP_WAIT : S_RUN;
      end
      S_RUN, S_STEP: begin
        o_back_en = 1'b1;
        if (state_q == S_STEP) state_d = S_STEP_WAIT;
        if (hazard) begin
          o_id_ex_bubble = 1'b1;
          if (stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
        end else if (i_halt_ID) begin
          o_id_ex_bubble = 1'b1;
          drain_cnt_d    = 2'd0;
          state_d        = S_DRAIN;
        end else begin
          o_pc_en       = 1'b1;
          o_if_id_en    = 1'b1;
          o_if_id_flush = i_take_ID;
        end
      end
      S_STEP_WAIT: begin
        if (i_step) state_d = S_STEP;
      end
      S_DRAIN: begin
        o_id_ex_bubble = 1'b1;
        o_back_en      = 1'b1;
        if (drain_cnt_q == DRAIN_END) begin
          drain_cnt_d = 2'd0;
          state_d     = S_HALTED;
        end else begin
          drain_cnt_d = drain_cnt_q + 2'd1;
        end
      end
      S_HALTED: begin
        o_halted = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    cycle_cnt_d = o_back_en ? (cycle_cnt_q + CNT_ONE) : cycle_cnt_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      drain_cnt_q <= 2'd0;
      cycle_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign o_state       = state_q;
  assign o_cycle_count = cycle_cnt_q;
  assign o_stall_count = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Randomized and directed bench for pipeline_hazard_controller against a
// cycle-level reference model of the sequencer's rules.
module tb_pipeline_hazard_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs, rt, rd_ex, rd_m;
  logic        uses_rs, uses_rt, branch, take, halt;
  logic        regwrite_ex, memread_ex, memread_m;
  logic        start, dbg_mode, step;
  logic        pc_en, if_id_en, if_id_flush, id_ex_bubble, back_en, halted;
  logic [2:0]  state;
  logic [31:0] cycle_count;
  logic [15:0] stall_count;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int          m_mode;        // 0 idle,1 run,2 step-wait,3 step,4 drain,5 halted
  int          m_drain_left;
  logic [31:0] m_cycles;
  int          m_stalls;

  always #5 clk = ~clk;

  pipeline_hazard_controller #(.NB_REG(5), .NB_CNT(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_rs_from_ID(rs), .i_rt_from_ID(rt),
    .i_uses_rs_ID(uses_rs), .i_uses_rt_ID(uses_rt),
    .i_branch_ID(branch), .i_take_ID(take), .i_halt_ID(halt),
    .i_rd_from_EX(rd_ex), .i_RegWrite_from_EX(regwrite_ex), .i_MemRead_from_EX(memread_ex),
    .i_rd_from_M(rd_m), .i_MemRead_from_M(memread_m),
    .i_start(start), .i_dbg_mode(dbg_mode), .i_step(step),
    .o_pc_en(pc_en), .o_if_id_en(if_id_en), .o_if_id_flush(if_id_flush),
    .o_id_ex_bubble(id_ex_bubble), .o_back_en(back_en), .o_halted(halted),
    .o_state(state), .o_cycle_count(cycle_count), .o_stall_count(stall_count)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [8:0] obs();
    return {pc_en, if_id_en, if_id_flush, id_ex_bubble, back_en, halted, state};
  endfunction

  function automatic bit reads(input logic [4:0] r);
    return (r != 5'd0) && ((uses_rs && r == rs) || (uses_rt && r == rt));
  endfunction

  task automatic clear_inputs();
    {rs, rt, rd_ex, rd_m} = '0;
    {uses_rs, uses_rt, branch, take, halt} = '0;
    {regwrite_ex, memread_ex, memread_m} = '0;
    {start, dbg_mode, step} = '0;
  endtask

  task automatic model_reset();
    m_mode = 0; m_drain_left = 0; m_cycles = '0; m_stalls = 0;
  endtask

  // Evaluate one cycle of the model at the negedge, compare, then advance.
  task automatic model_cycle();
    bit active, stall_now;
    bit e_pc, e_ifid, e_fl, e_bub, e_back, e_halt;
    int next_mode;
    active    = (m_mode == 1) || (m_mode == 3);
    stall_now = active && ((memread_ex && reads(rd_ex)) ||
                           (branch && regwrite_ex && reads(rd_ex)) ||
                           (branch && memread_m && reads(rd_m)));
    {e_pc, e_ifid, e_fl, e_bub, e_back} = '0;
    e_halt    = (m_mode == 5);
    next_mode = m_mode;
    if (active) begin
      e_back    = 1;
      next_mode = (m_mode == 3) ? 2 : 1;
      if (stall_now) begin
        e_bub = 1;
      end else if (halt) begin
        e_bub = 1; next_mode = 4; m_drain_left = 3;
      end else begin
        e_pc = 1; e_ifid = 1; e_fl = take;
      end
    end else if (m_mode == 0 && start) begin
      next_mode = dbg_mode ? 2 : 1;
    end else if (m_mode == 2 && step) begin
      next_mode = 3;
    end else if (m_mode == 4) begin
      e_bub = 1; e_back = 1;
      m_drain_left--;
      if (m_drain_left == 0) next_mode = 5;
    end
    chk("ctl", obs(), {e_pc, e_ifid, e_fl, e_bub, e_back, e_halt, 3'(m_mode)});
    chk("cycles", cycle_count, m_cycles);
    chk("stalls", stall_count, 16'(m_stalls));
    if (e_back) m_cycles = m_cycles + 1;
    if (stall_now && m_stalls < 65535) m_stalls++;
    m_mode = next_mode;
  endtask

  // Called at posedge+1 with inputs already driven; returns at next posedge+1.
  task automatic tick();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    #2;
    chk("rst_ctl", 64'(obs()), 64'd0);
    chk("rst_cnt", {cycle_count, stall_count}, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Continuous run, no hazards
    start = 1; tick(); start = 0;
    tick();
    chk("run_state", state, 3'd1);
    tick();

    // Load-use: stall then clear once the load reaches M
    memread_ex = 1; regwrite_ex = 1; rd_ex = 3; rs = 3; uses_rs = 1;
    tick();
    chk("lu_stall_count", stall_count, 16'd1);
    memread_ex = 0; regwrite_ex = 0; rd_ex = 0; memread_m = 1; rd_m = 3;
    tick();
    memread_m = 0; rd_m = 0;
    memread_ex = 1; rd_ex = 0; rs = 0; tick();          // rd=0 never stalls
    rd_ex = 3; rs = 3; uses_rs = 0; tick();              // operand not read
    chk("lu_no_stall", stall_count, 16'd1);
    clear_inputs();

    // Branch after a load: br_ex then br_m
    branch = 1; rt = 4; uses_rt = 1;
    memread_ex = 1; regwrite_ex = 1; rd_ex = 4; tick();
    memread_ex = 0; regwrite_ex = 0; rd_ex = 0; memread_m = 1; rd_m = 4; tick();
    chk("br_stall_count", stall_count, 16'd3);
    memread_m = 0; rd_m = 0; take = 1; tick();
    take = 0; branch = 0; tick();

    // HALT and drain
    halt = 1; tick(); halt = 0;
    repeat (3) tick();
    chk("halted_flag", halted, 1'b1);
    start = 1; tick(); start = 0;
    step = 1; tick(); step = 0;
    chk("halted_state", state, 3'd5);

    // Step mode: three pulses five cycles apart
    do_reset();
    dbg_mode = 1; start = 1; tick(); start = 0; dbg_mode = 0;
    for (int k = 0; k < 3; k++) begin
      step = 1; tick(); step = 0;
      repeat (4) tick();
    end
    chk("step_cycles", cycle_count, 32'd3);

    // Asynchronous reset in the second DRAIN cycle
    do_reset();
    start = 1; tick(); start = 0;
    tick();
    halt = 1; tick(); halt = 0;
    tick();
    chk("drain2_state", state, 3'd4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_ctl", 64'(obs()), 64'd0);
    chk("async_cnt", {cycle_count, stall_count}, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    clear_inputs();
    tick();

    // Randomized episodes
    for (int ep = 0; ep < 40; ep++) begin
      do_reset();
      for (int c = 0; c < 150; c++) begin
        rs          = 5'($urandom_range(0, 3));
        rt          = 5'($urandom_range(0, 3));
        rd_ex       = 5'($urandom_range(0, 3));
        rd_m        = 5'($urandom_range(0, 3));
        uses_rs     = 1'($urandom);
        uses_rt     = 1'($urandom);
        branch      = 1'($urandom);
        take        = 1'($urandom);
        regwrite_ex = 1'($urandom);
        memread_ex  = 1'($urandom);
        memread_m   = 1'($urandom);
        halt        = ($urandom_range(0, 39) == 0);
        start       = ($urandom_range(0, 7) == 0);
        dbg_mode    = 1'($urandom);
        step        = ($urandom_range(0, 2) == 0);
        tick();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_controller.md
# pipeline_hazard_controller

Central stall/flush/run sequencer for the 5-stage MIPS pipeline. It sits beside the EX forwarding unit and covers the hazards forwarding cannot resolve: load-use, branch-in-ID operand dependence, and control-flow flush. It also owns the run/step/halt sequence driven by the debug unit, including draining the pipeline after a HALT instruction. It drives the enable, flush and bubble controls for the PC, IF/ID, ID/EX and back-end pipeline registers, and reports cycle and stall counters.

## Interface
- NB_REG, 5, register index width
- NB_CNT, 32, cycle counter width (stall counter is 16 bits, fixed)

- i_clk  in  1  clock; all state updates on the rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_rs_from_ID, i_rt_from_ID  in  NB_REG  source registers of the instruction in ID
- i_uses_rs_ID, i_uses_rt_ID  in  1  ID instruction actually reads rs / rt
- i_branch_ID  in  1  ID instruction is a branch or JR; it compares or reads registers in ID
- i_take_ID  in  1  branch or jump in ID resolved as taken
- i_halt_ID  in  1  HALT opcode in ID
- i_rd_from_EX  in  NB_REG  destination register in EX
- i_RegWrite_from_EX, i_MemRead_from_EX  in  1  EX-stage control
- i_rd_from_M  in  NB_REG  destination register in M
- i_MemRead_from_M  in  1  M-stage load
- i_start  in  1  pulse from debug unit; leaves IDLE
- i_dbg_mode  in  1  0 = continuous, 1 = step; sampled only in IDLE
- i_step  in  1  pulse; one pipeline advance in step mode
- o_pc_en, o_if_id_en  out  1  write enables for the PC and IF/ID registers
- o_if_id_flush  out  1  clear IF/ID to NOP
- o_id_ex_bubble  out  1  load NOP controls into ID/EX
- o_back_en  out  1  enable for the ID/EX, EX/M and M/WB registers
- o_halted  out  1  pipeline fully drained after HALT
- o_state  out  3  FSM state encoding, for the debug unit
- o_cycle_count  out  NB_CNT  cycles with o_back_en=1
- o_stall_count  out  16  hazard-stall cycles; saturates at 0xFFFF

## Operation
- States:
  - IDLE=0: all enables 0. On i_start, go to RUN if i_dbg_mode=0, else STEP_WAIT.
  - RUN=1: pipeline advances each cycle under the hazard rules.
  - STEP_WAIT=2: all enables 0. On i_step, go to STEP.
  - STEP=3: exactly one RUN-equivalent cycle, then return to STEP_WAIT.
  - DRAIN=4: PC and IF/ID frozen, ID/EX bubbled, back end enabled. Lasts 3 cycles (2-bit counter), then goes to HALTED.
  - HALTED=5: all enables 0, o_halted=1. Left only by reset. i_start and i_step are ignored.
- Hazard terms, evaluated only in RUN and STEP. A register "matches" when it is nonzero and equals an rs or rt whose uses_* bit is 1.
  - load_use = i_MemRead_from_EX && i_rd_from_EX matches.
  - br_ex = i_branch_ID && i_RegWrite_from_EX && i_rd_from_EX matches.
  - br_m = i_branch_ID && i_MemRead_from_M && i_rd_from_M matches.
  - stall = load_use | br_ex | br_m.
- Active cycle (RUN or STEP), evaluated in priority order:
  - stall: pc_en=0, if_id_en=0, id_ex_bubble=1, back_en=1; stall counter increments. Halt and take are ignored this cycle.
  - i_halt_ID: pc_en=0, if_id_en=0, id_ex_bubble=1, back_en=1; next state DRAIN. This applies from STEP as well, and the drain then runs without further i_step pulses.
  - otherwise: pc_en=1, if_id_en=1, back_en=1. o_if_id_flush=i_take_ID. The architecture has no delay slot.
- Enables are Mealy outputs: a function of the registered state plus current inputs. The counters and the drain counter are registered.
- An i_step arriving in STEP is ignored. An i_start arriving outside IDLE is ignored.

## Timing
- Reset (asynchronous assert): state IDLE, drain counter 0, both counters 0. All enable, flush and bubble outputs 0. o_halted=0, o_state=0. Release is synchronous to i_clk.
- i_start high at edge N: RUN is active, and o_pc_en=1, from cycle N+1.
- Load-use stall lasts exactly 1 cycle. The stall clears because the load moves to M.
- br_ex gives 1 stall cycle, then br_m gives a second, so a branch after a load stalls 2 cycles.
- HALT in ID at cycle N: DRAIN covers cycles N+1..N+3, and o_halted=1 from N+4.
- o_cycle_count wraps modulo 2^NB_CNT. o_stall_count does not wrap.
- Reset mid-DRAIN or mid-stall returns to IDLE immediately, with no residual enables.

## Test plan
- Reset, then i_start with i_dbg_mode=0 -> RUN next cycle. With no hazards, pc_en=if_id_en=back_en=1 and o_stall_count=0.
- EX: lw $3 (MemRead=1, rd=3). ID: add reads rs=3 (uses_rs=1) -> one cycle with pc_en=0, bubble=1; o_stall_count=1. Repeat with rd=0, or with uses_rs=0 -> no stall.
- beq in ID reading rt=4, preceded by lw $4 -> 2 stall cycles (br_ex then br_m). Then i_take_ID=1 -> o_if_id_flush=1 for 1 cycle.
- i_halt_ID in RUN -> 3 DRAIN cycles with back_en=1, pc_en=0, then o_halted=1, o_state=5. i_start afterwards changes nothing.
- Step mode: 3 i_step pulses spaced 5 cycles apart -> exactly 3 cycles with back_en=1, and o_cycle_count=3.
- Assert i_rst_n=0 during the second DRAIN cycle -> all outputs 0 and state IDLE without waiting for a clock edge.
